// File: rtl/dmem_ctrl.sv
// Byte-addressed RV32I data memory with sized/signed loads, byte-enable stores and fault reporting.
// Responds LATENCY cycles after acceptance (faults after 1); one request outstanding, no response backpressure.
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              busy
);

  localparam int              IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);
  localparam logic [2:0]      LOAD_CNT   = 3'(LATENCY - 2);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic             accept, illegal, misaligned, out_of_range, fault, st_en;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword, ld_data, st_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [3:0]       be;

  always_comb begin
    accept = req_valid && req_ready_q;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
    misaligned   = ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0]) ||
                   (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
    out_of_range = {1'b0, req_addr} >= ADDR_LIMIT;
    fault        = illegal || misaligned || out_of_range;

    idx     = req_addr[2 +: IDX_W];
    rword   = mem_q[idx];
    ld_byte = rword[{req_addr[1:0], 3'b000} +: 8];
    ld_half = req_addr[1] ? rword[31:16] : rword[15:0];
    case (req_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = rword;
    endcase

    // Store data is replicated across lanes so the byte enables alone pick the target.
    case (req_funct3)
      3'b000: begin
        be      = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        be      = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = req_wdata;
      end
    endcase
    st_en = accept && req_we && !fault;
  end

  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_rdata_d = 32'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else if (LATENCY == 1) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_we ? 32'b0 : ld_data;
          end else begin
            state_d     = WAIT;
            cnt_d       = LOAD_CNT;
            hold_d      = req_we ? 32'b0 : ld_data;
            req_ready_d = 1'b0;
            busy_d      = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = hold_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      hold_q      <= 32'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench: one single-cycle and one LATENCY=4 instance, directed vectors with hand-computed results.
module tb_dmem_ctrl;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        f;
  } exp_t;

  logic        clk;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        done = 1'b0;
  exp_t        q1[$];
  exp_t        q4[$];

  logic        rst1, v1, rdy1, we1, rv1, rf1, bz1;
  logic [31:0] addr1, wd1, rd1;
  logic [2:0]  f31;
  logic        rst4, v4, rdy4, we4, rv4, rf4, bz4;
  logic [31:0] addr4, wd4, rd4;
  logic [2:0]  f34;

  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(addr1), .req_funct3(f31), .req_wdata(wd1), .rsp_valid(rv1),
    .rsp_rdata(rd1), .rsp_fault(rf1), .busy(bz1)
  );

  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(rst4), .req_valid(v4), .req_ready(rdy4), .req_we(we4),
    .req_addr(addr4), .req_funct3(f34), .req_wdata(wd4), .rsp_valid(rv4),
    .rsp_rdata(rd4), .rsp_fault(rf4), .busy(bz4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; returns one falling edge after acceptance with valid dropped.
  task automatic issue(input int inst, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_f,
                       input logic push);
    exp_t e;
    int   k;
    if (inst == 1) begin
      v1 = 1'b1; we1 = we; addr1 = addr; f31 = f3; wd1 = wd;
    end else begin
      v4 = 1'b1; we4 = we; addr4 = addr; f34 = f3; wd4 = wd;
    end
    k = 0;
    while (((inst == 1) ? rdy1 : rdy4) !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (((inst == 1) ? rdy1 : rdy4) !== 1'b1) begin
      check("issue_ready_timeout", {31'b0, (inst == 1) ? rdy1 : rdy4}, 32'd1);
    end else if (push) begin
      e.cyc = cyc + ((exp_f || inst == 1) ? 1 : 4);
      e.rd  = exp_rd;
      e.f   = exp_f;
      if (inst == 1) q1.push_back(e);
      else           q4.push_back(e);
    end
    @(negedge clk);
    if (inst == 1) v1 = 1'b0;
    else           v4 = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   t0;
    int   k;
    rst1 = 1'b1; v1 = 1'b0; we1 = 1'b0; addr1 = '0; f31 = '0; wd1 = '0;
    rst4 = 1'b1; v4 = 1'b0; we4 = 1'b0; addr4 = '0; f34 = '0; wd4 = '0;
    @(negedge clk);
    check("l1_rst_ready", rdy1, 1);  check("l1_rst_busy", bz1, 0);
    check("l1_rst_rsp_valid", rv1, 0);  check("l1_rst_rdata", rd1, 0);  check("l1_rst_fault", rf1, 0);
    check("l4_rst_ready", rdy4, 1);  check("l4_rst_busy", bz4, 0);
    check("l4_rst_rsp_valid", rv4, 0);  check("l4_rst_rdata", rd4, 0);  check("l4_rst_fault", rf4, 0);
    @(negedge clk);
    rst1 = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);

    fork
      begin : monitor
        while (!done) begin
          @(negedge clk);
          if (rv1) begin
            if (q1.size() == 0) check("l1_unexpected_rsp", rv1, 0);
            else begin
              e = q1.pop_front();
              check("l1_rsp_cycle", cyc, e.cyc);
              check("l1_rsp_rdata", rd1, e.rd);
              check("l1_rsp_fault", rf1, e.f);
            end
          end else begin
            check("l1_idle_rdata", rd1, 0);
            check("l1_idle_fault", rf1, 0);
          end
          if (rv4) begin
            if (q4.size() == 0) check("l4_unexpected_rsp", rv4, 0);
            else begin
              e = q4.pop_front();
              check("l4_rsp_cycle", cyc, e.cyc);
              check("l4_rsp_rdata", rd4, e.rd);
              check("l4_rsp_fault", rf4, e.f);
            end
          end else begin
            check("l4_idle_rdata", rd4, 0);
            check("l4_idle_fault", rf4, 0);
          end
        end
      end
      begin : stimulus
        // Single-cycle instance: back-to-back traffic, ready must never drop.
        issue(1, 1, 32'h10, 3'b010, 32'h8badf00d, 32'h0, 0, 1);
        issue(1, 0, 32'h10, 3'b010, 32'h0, 32'h8badf00d, 0, 1);
        issue(1, 0, 32'h13, 3'b000, 32'h0, 32'hffffff8b, 0, 1);
        issue(1, 0, 32'h13, 3'b100, 32'h0, 32'h0000008b, 0, 1);
        issue(1, 0, 32'h12, 3'b001, 32'h0, 32'hffff8bad, 0, 1);
        issue(1, 0, 32'h10, 3'b101, 32'h0, 32'h0000f00d, 0, 1);
        issue(1, 1, 32'h11, 3'b000, 32'h000000aa, 32'h0, 0, 1);
        issue(1, 0, 32'h10, 3'b010, 32'h0, 32'h8badaa0d, 0, 1);
        issue(1, 0, 32'h10, 3'b000, 32'h0, 32'h0000000d, 0, 1);
        issue(1, 0, 32'h10, 3'b001, 32'h0, 32'hffffaa0d, 0, 1);
        issue(1, 1, 32'h12, 3'b001, 32'h00001234, 32'h0, 0, 1);
        issue(1, 0, 32'h12, 3'b000, 32'h0, 32'h00000034, 0, 1);
        issue(1, 1, 32'h0, 3'b010, 32'h11111111, 32'h0, 0, 1);
        check("l1_ready_full_tput", rdy1, 1);
        // Faults: misaligned, illegal, out of range; none may touch memory.
        issue(1, 0, 32'h12, 3'b010, 32'h0, 32'h0, 1, 1);
        issue(1, 1, 32'h01, 3'b001, 32'h0000ffff, 32'h0, 1, 1);
        issue(1, 0, 32'h400, 3'b010, 32'h0, 32'h0, 1, 1);
        issue(1, 0, 32'h10, 3'b011, 32'h0, 32'h0, 1, 1);
        issue(1, 1, 32'h12, 3'b010, 32'hdeadbeef, 32'h0, 1, 1);
        issue(1, 1, 32'h400, 3'b010, 32'hdeadbeef, 32'h0, 1, 1);
        issue(1, 1, 32'h10, 3'b100, 32'h000000ff, 32'h0, 1, 1);
        issue(1, 0, 32'h10, 3'b010, 32'h0, 32'h1234aa0d, 0, 1);
        issue(1, 0, 32'h0, 3'b010, 32'h0, 32'h11111111, 0, 1);

        // LATENCY=4 instance.
        issue(4, 1, 32'h20, 3'b010, 32'h12345678, 32'h0, 0, 1);
        issue(4, 0, 32'h22, 3'b010, 32'h0, 32'h0, 1, 1);
        k = 0;
        while (rdy4 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check("l4_idle_before_timing", rdy4, 1);
        t0 = cyc;
        v4 = 1'b1; we4 = 1'b0; addr4 = 32'h20; f34 = 3'b010; wd4 = 32'h0;
        e.cyc = t0 + 4; e.rd = 32'h12345678; e.f = 1'b0;
        q4.push_back(e);
        @(negedge clk);
        addr4 = 32'h22; f34 = 3'b101;
        for (int i = 1; i <= 3; i++) begin
          check("l4_wait_ready", rdy4, 0);
          check("l4_wait_busy", bz4, 1);
          @(negedge clk);
        end
        check("l4_ready_at_rsp", rdy4, 1);
        check("l4_busy_at_rsp", bz4, 0);
        e.cyc = t0 + 8; e.rd = 32'h00001234; e.f = 1'b0;
        q4.push_back(e);
        @(negedge clk);
        v4 = 1'b0;
        check("l4_busy_second", bz4, 1);

        // Reset during WAIT discards the pending load.
        issue(4, 0, 32'h20, 3'b010, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #1 rst4 = 1'b1;
        #1;
        check("l4_midrst_ready", rdy4, 1);
        check("l4_midrst_busy", bz4, 0);
        check("l4_midrst_rsp_valid", rv4, 0);
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        check("l4_postrst_ready", rdy4, 1);
        check("l4_postrst_busy", bz4, 0);
        @(negedge clk);
        issue(4, 0, 32'h20, 3'b010, 32'h0, 32'h12345678, 0, 1);

        k = 0;
        while ((q1.size() != 0 || q4.size() != 0) && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        done = 1'b1;
      end
    join

    check("l1_drain", q1.size(), 0);
    check("l4_drain", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
